// File: rtl/mem_a_pkg.sv
// Shared helpers for the operand-A staging memory.
package mem_a_pkg;

  // Index width for a DEPTH-entry dimension; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_a_row.sv
// One matrix row: zero-fill shift register with write port, feeding a LANE+1 deep skew chain.
// Latency: element in column 0 reaches dout LANE+1 enabled edges later; no backpressure, en gates everything.
module mem_a_row
  import mem_a_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DEPTH   = 8,
  parameter int LANE    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          wr_en,
  input  logic [idx_w(DEPTH)-1:0]       col,
  input  logic signed [BITS_AB-1:0]     din,
  output logic signed [BITS_AB-1:0]     dout
);

  localparam int IW = idx_w(DEPTH);
  localparam logic [IW:0] DEPTH_W = DEPTH[IW:0];

  logic signed [BITS_AB-1:0] mem  [DEPTH];
  logic signed [BITS_AB-1:0] skew [LANE+1];
  logic                      col_ok;

  assign col_ok = ({1'b0, col} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < DEPTH; c++) mem[c] <= '0;
      for (int k = 0; k <= LANE; k++) skew[k] <= '0;
    end else begin
      if (en) begin
        for (int c = 0; c < DEPTH - 1; c++) mem[c] <= mem[c+1];
        mem[DEPTH-1] <= '0;
        skew[0] <= mem[0];
        for (int k = 1; k <= LANE; k++) skew[k] <= skew[k-1];
      end
      // Placed after the shift so a same-cycle write overrides the shifted value.
      if (wr_en && col_ok) mem[col] <= din;
    end
  end

  assign dout = skew[LANE];

endmodule

// File: rtl/mem_a.sv
// Operand-A staging memory: DEPTH x DEPTH matrix streamed row-parallel with a diagonal skew.
// Latency: row r appears r+1 enabled edges after en; no backpressure, consumer counts en cycles.
module mem_a
  import mem_a_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          WrEn,
  input  logic [idx_w(DEPTH)-1:0]       row,
  input  logic [idx_w(DEPTH)-1:0]       col,
  input  logic signed [BITS_AB-1:0]     Ain,
  output logic signed [BITS_AB-1:0]     Aout [DEPTH-1:0]
);

  localparam int IW = idx_w(DEPTH);

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    logic wr_row;
    // Out-of-range row indices match no lane and are dropped.
    assign wr_row = WrEn && ({1'b0, row} == (IW+1)'(r));

    mem_a_row #(
      .BITS_AB (BITS_AB),
      .DEPTH   (DEPTH),
      .LANE    (r)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .wr_en (wr_row),
      .col   (col),
      .din   (Ain),
      .dout  (Aout[r])
    );
  end

endmodule

// File: tb/tb_mem_a.sv
// Self-checking bench for mem_a: skew-window formula and a queue-based stream model.
module tb_mem_a;

  localparam int B = 8;
  localparam int D = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 WrEn = 1'b0;
  logic [2:0]           row = '0;
  logic [2:0]           col = '0;
  logic signed [B-1:0]  Ain = '0;
  logic signed [B-1:0]  aout [D-1:0];

  int checks = 0;
  int errors = 0;

  int A [D][D];       // matrix as loaded, for the window formula
  int m [D][D];       // matrix contents as the stream consumes it
  int hist [D][$];    // values leaving column 0, one per enabled edge

  mem_a #(.BITS_AB(B), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .WrEn  (WrEn),
    .row   (row),
    .col   (col),
    .Ain   (Ain),
    .Aout  (aout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < D; r++) begin
      hist[r].delete();
      for (int c = 0; c < D; c++) begin
        A[r][c] = 0;
        m[r][c] = 0;
      end
    end
  endtask

  // One clock edge of both DUT and model with the given controls.
  task automatic step(input logic e, input logic we, input int r_i, input int c_i, input int v);
    en = e; WrEn = we; row = r_i[2:0]; col = c_i[2:0]; Ain = v[B-1:0];
    tick();
    if (e) begin
      for (int r = 0; r < D; r++) begin
        hist[r].push_back(m[r][0]);
        for (int c = 0; c < D - 1; c++) m[r][c] = m[r][c+1];
        m[r][D-1] = 0;
      end
    end
    if (we) begin
      m[r_i][c_i] = v;
      if (!e) A[r_i][c_i] = v;
    end
    en = 1'b0; WrEn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; WrEn = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic check_window(input int k, input string name);
    int c, exp;
    for (int r = 0; r < D; r++) begin
      c = k - 1 - r;
      exp = (c >= 0 && c < D) ? A[r][c] : 0;
      checks++;
      if (int'(aout[r]) !== exp) begin
        errors++;
        $display("FAIL %s edge %0d lane %0d: got %0d expected %0d", name, k, r, aout[r], exp);
      end
    end
  endtask

  task automatic check_model(input string name);
    int n, exp;
    for (int r = 0; r < D; r++) begin
      n = hist[r].size();
      exp = (n > r) ? hist[r][n-1-r] : 0;
      checks++;
      if (int'(aout[r]) !== exp) begin
        errors++;
        $display("FAIL %s lane %0d: got %0d expected %0d", name, r, aout[r], exp);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_window(0, "reset");
  endtask

  task automatic test_idle_stream();
    do_reset();
    for (int k = 1; k <= 3 * D; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_window(k, "idle");
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) step(1'b0, 1'b1, r, c, r * D + c);
    for (int k = 1; k <= 2 * D; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_window(k, "ramp");
    end
  endtask

  task automatic test_random_signed();
    do_reset();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) step(1'b0, 1'b1, r, c, int'($urandom_range(0, 254)) - 127);
    A[3][0] = -127; step(1'b0, 1'b1, 3, 0, -127);
    for (int k = 1; k <= 2 * D + 1; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_window(k, "rand");
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) step(1'b0, 1'b1, r, c, int'($urandom_range(0, 254)) - 127);
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      check_window(4, "pause_hold");
    end
    for (int k = 5; k <= 2 * D; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_window(k, "pause_resume");
    end
  endtask

  task automatic test_concurrent_write();
    bit seen = 0;
    do_reset();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) step(1'b0, 1'b1, r, c, r * D + c);
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_model("conc_pre");
    end
    step(1'b1, 1'b1, 2, 7, -5);
    check_model("conc_edge");
    for (int k = 0; k < 3 * D; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_model("conc_post");
      if (int'(aout[2]) == -5) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL conc_seen: lane 2 never showed -5 (got seen=%0d expected 1)", seen);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) step(1'b0, 1'b1, r, c, r * D + c + 1);
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 0, 0, 0);
    check_window(5, "pre_arst");
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_window(0, "arst_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 1; k <= 2 * D + 2; k++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      check_window(k, "post_arst");
    end
  endtask

  initial begin
    test_reset();
    test_idle_stream();
    test_ramp();
    test_random_signed();
    test_pause();
    test_concurrent_write();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
